aes32_dround_seq: RTL and testbench

// - Sequences one shared 32-bit aes32dsmi datapath through a full 128-bit AES decryption middle round.
// - The round is 16 issue cycles: 4 output columns x 4 byte selects.
// - Sits between the block-level AES decrypt controller (valid/ready upstream/downstream) and the single
//   aes32dsmi instance, which is external and driven combinationally through the dp_* ports.

---
 rtl/aes32_dround_seq.sv | 144 ++++++++++++++
 tb/tb_aes32_dround_seq.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes32_dround_seq.sv
// aes32_dround_seq: drives one shared aes32dsmi datapath for a full AES decrypt round.
// Optional feature macro: AES32_SEQ_LAST_EN (adds last_in / dp_last for aes32dsi final rounds).
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   request handshake (state_in, rk_in, last_in)
//   out_valid / out_ready result handshake (state_out)
//   busy                  high while a round is running or a result is waiting
//   dp_bs/dp_rs1/dp_rs2   operands to the external datapath
//   dp_rd                 combinational datapath result
//   dp_last               aes32dsi select (AES32_SEQ_LAST_EN only)
module aes32_dround_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic [127:0] rk_in,
`ifdef AES32_SEQ_LAST_EN
    input  logic         last_in,
    output logic         dp_last,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy,
    output logic [1:0]   dp_bs,
    output logic [31:0]  dp_rs1,
    output logic [31:0]  dp_rs2,
    input  logic [31:0]  dp_rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           st;
    logic [3:0]       cnt;
    logic [31:0]      acc;
    logic [3:0][31:0] s_q;
    logic [3:0][31:0] rk_q;
    logic [2:0][31:0] t_q;
    logic [1:0]       col;
    logic [1:0]       bs;
    logic [1:0]       sel;
    logic             accept;
`ifdef AES32_SEQ_LAST_EN
    logic             last_q;
`endif

    assign col = cnt[3:2];
    assign bs  = cnt[1:0];
    // InvShiftRows: byte bs of column col comes from word (col - bs) mod 4
    assign sel = col - bs;

    assign in_ready = (st == IDLE) || ((st == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        dp_bs  = 2'd0;
        dp_rs1 = 32'd0;
        dp_rs2 = 32'd0;
        if (st == RUN) begin
            dp_bs  = bs;
            dp_rs2 = s_q[sel];
            // first byte of each column starts from the round key word
            dp_rs1 = (bs == 2'd0) ? rk_q[col] : acc;
        end
    end

`ifdef AES32_SEQ_LAST_EN
    assign dp_last = (st == RUN) && last_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            cnt       <= 4'd0;
            acc       <= 32'd0;
            s_q       <= '0;
            rk_q      <= '0;
            t_q       <= '0;
            state_out <= 128'd0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef AES32_SEQ_LAST_EN
            last_q    <= 1'b0;
`endif
        end else begin
            if (accept) begin
                s_q  <= state_in;
                rk_q <= rk_in;
                cnt  <= 4'd0;
`ifdef AES32_SEQ_LAST_EN
                last_q <= last_in;
`endif
            end
            unique case (st)
                IDLE: begin
                    if (accept) begin
                        st   <= RUN;
                        busy <= 1'b1;
                    end
                end
                RUN: begin
                    acc <= dp_rd;
                    cnt <= cnt + 4'd1;
                    if (bs == 2'd3) begin
                        case (col)
                            2'd0:    t_q[0] <= dp_rd;
                            2'd1:    t_q[1] <= dp_rd;
                            2'd2:    t_q[2] <= dp_rd;
                            default: ;
                        endcase
                    end
                    // publish the whole block at once so no partial result is visible
                    if (cnt == 4'd15) begin
                        state_out <= {dp_rd, t_q[2], t_q[1], t_q[0]};
                        out_valid <= 1'b1;
                        st        <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            st <= RUN;
                        end else begin
                            st   <= IDLE;
                            busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    st   <= IDLE;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes32_dround_seq.sv
// tb_aes32_dround_seq: directed bench for aes32_dround_seq with a behavioural
// aes32dsmi/aes32dsi datapath model closing the dp_* loop.
module tb_aes32_dround_seq;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic [127:0] rk_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;
    logic [1:0]   dp_bs;
    logic [31:0]  dp_rs1;
    logic [31:0]  dp_rs2;
    logic [31:0]  dp_rd;
    logic         model_last;
`ifdef AES32_SEQ_LAST_EN
    logic         last_in;
    logic         dp_last;
`endif

    int n_pass = 0;
    int n_chk  = 0;
    int ord[16] = '{0, 3, 2, 1, 1, 0, 3, 2, 2, 1, 0, 3, 3, 2, 1, 0};

    logic [7:0] inv_sb[256];
    logic       tbl_ok;

    aes32_dround_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .rk_in     (rk_in),
`ifdef AES32_SEQ_LAST_EN
        .last_in   (last_in),
        .dp_last   (dp_last),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy),
        .dp_bs     (dp_bs),
        .dp_rs1    (dp_rs1),
        .dp_rs2    (dp_rs2),
        .dp_rd     (dp_rd)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++)
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                   ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] dsmi(input logic [1:0] bs, input logic [31:0] rs1,
                                         input logic [31:0] rs2, input logic last);
        logic [7:0]  so;
        logic [31:0] w;
        logic [63:0] d;
        so = inv_sb[rs2[8*bs +: 8]];
        if (last) w = {24'h0, so};
        else      w = {gmul(so, 8'h0b), gmul(so, 8'h0d), gmul(so, 8'h09), gmul(so, 8'h0e)};
        d = {w, w} << (8 * bs);
        return d[63:32] ^ rs1;
    endfunction

    function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [127:0] r;
        logic [31:0]  a;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a = rk[32*c +: 32];
            for (int b = 0; b < 4; b++)
                a = dsmi(2'(b), a, s[32*ord[4*c+b] +: 32], last);
            r[32*c +: 32] = a;
        end
        return r;
    endfunction

`ifdef AES32_SEQ_LAST_EN
    assign model_last = dp_last;
`else
    assign model_last = 1'b0;
`endif
    assign dp_rd = tbl_ok ? dsmi(dp_bs, dp_rs1, dp_rs2, model_last) : 32'h0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_req(input logic [127:0] s, input logic [127:0] rk, input logic last);
        int w;
        w = 0;
        state_in = s;
        rk_in    = rk;
`ifdef AES32_SEQ_LAST_EN
        last_in  = last;
`else
        if (last) $display("note: last ignored in this build");
`endif
        in_valid = 1'b1;
        #1;
        while (!in_ready && w < 50) begin
            step();
            w++;
        end
        n_chk++;
        if (in_ready !== 1'b1)
            $display("FAIL accept_wait in_ready=%b want 1", in_ready);
        else n_pass++;
        step();
        in_valid = 1'b0;
    endtask

    task automatic run_body(input logic [127:0] s, input logic [127:0] rk,
                            input logic last, input logic [127:0] exp);
        for (int k = 0; k < 16; k++) begin
            n_chk++;
            if (dp_bs !== 2'(k % 4) || dp_rs2 !== s[32*ord[k] +: 32] ||
                out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0)
                $display("FAIL run_k%0d bs=%0d rs2=%h ov=%b busy=%b ir=%b want bs=%0d rs2=%h ov=0 busy=1 ir=0",
                         k, dp_bs, dp_rs2, out_valid, busy, in_ready, k % 4, s[32*ord[k] +: 32]);
            else n_pass++;
            if (k % 4 == 0) begin
                n_chk++;
                if (dp_rs1 !== rk[32*(k/4) +: 32])
                    $display("FAIL rs1_col%0d got %h want %h", k / 4, dp_rs1, rk[32*(k/4) +: 32]);
                else n_pass++;
            end
`ifdef AES32_SEQ_LAST_EN
            n_chk++;
            if (dp_last !== last)
                $display("FAIL dp_last_k%0d got %b want %b", k, dp_last, last);
            else n_pass++;
`else
            if (last) $display("note: last ignored in this build");
`endif
            step();
        end
        n_chk++;
        if (out_valid !== 1'b1 || state_out !== exp)
            $display("FAIL result ov=%b out=%h want ov=1 out=%h", out_valid, state_out, exp);
        else n_pass++;
    endtask

    task automatic release_out(input logic [127:0] exp);
        out_ready = 1'b1;
        #1;
        n_chk++;
        if (in_ready !== 1'b1)
            $display("FAIL done_in_ready got %b want 1", in_ready);
        else n_pass++;
        step();
        out_ready = 1'b0;
        n_chk++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || state_out !== exp || in_ready !== 1'b1)
            $display("FAIL idle_after ov=%b busy=%b ir=%b out=%h want 0 0 1 %h",
                     out_valid, busy, in_ready, state_out, exp);
        else n_pass++;
    endtask

    task automatic test_reset();
        #3;
        n_chk++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || state_out !== 128'h0 ||
            dp_bs !== 2'd0 || dp_rs1 !== 32'h0 || dp_rs2 !== 32'h0)
            $display("FAIL reset ov=%b busy=%b out=%h bs=%0d rs1=%h rs2=%h want all 0",
                     out_valid, busy, state_out, dp_bs, dp_rs1, dp_rs2);
        else n_pass++;
        n_chk++;
        if (in_ready !== 1'b1)
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_zero();
        accept_req(128'h0, 128'h0, 1'b0);
        run_body(128'h0, 128'h0, 1'b0, {16{8'h52}});
        release_out({16{8'h52}});
    endtask

    task automatic test_ones();
        accept_req(128'h0, {128{1'b1}}, 1'b0);
        run_body(128'h0, {128{1'b1}}, 1'b0, {16{8'had}});
        release_out({16{8'had}});
    endtask

    task automatic test_order();
        logic [127:0] s;
        logic [127:0] rk;
        s  = 128'h33221100_77665544_bbaa9988_ffeeddcc;
        rk = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
        accept_req(s, rk, 1'b0);
        run_body(s, rk, 1'b0, ref_round(s, rk, 1'b0));
        release_out(ref_round(s, rk, 1'b0));
    endtask

    task automatic test_back_to_back();
        logic [127:0] s1, rk1, s2, rk2, e1, e2;
        s1  = {$urandom, $urandom, $urandom, $urandom};
        rk1 = {$urandom, $urandom, $urandom, $urandom};
        s2  = {$urandom, $urandom, $urandom, $urandom};
        rk2 = {$urandom, $urandom, $urandom, $urandom};
        e1  = ref_round(s1, rk1, 1'b0);
        e2  = ref_round(s2, rk2, 1'b0);
        accept_req(s1, rk1, 1'b0);
        run_body(s1, rk1, 1'b0, e1);
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            if (state_out !== e1 || in_ready !== 1'b0 || out_valid !== 1'b1)
                $display("FAIL stall_%0d out=%h ir=%b ov=%b want %h 0 1",
                         i, state_out, in_ready, out_valid, e1);
            else n_pass++;
            step();
        end
        state_in  = s2;
        rk_in     = rk2;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        n_chk++;
        if (in_ready !== 1'b1)
            $display("FAIL b2b_in_ready got %b want 1", in_ready);
        else n_pass++;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        run_body(s2, rk2, 1'b0, e2);
        release_out(e2);
    endtask

    task automatic test_reset_mid();
        logic [127:0] s, rk;
        s  = {$urandom, $urandom, $urandom, $urandom};
        rk = {$urandom, $urandom, $urandom, $urandom};
        accept_req(s, rk, 1'b0);
        for (int i = 0; i < 7; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || state_out !== 128'h0 ||
            dp_bs !== 2'd0 || dp_rs1 !== 32'h0 || dp_rs2 !== 32'h0 || in_ready !== 1'b1)
            $display("FAIL mid_reset ov=%b busy=%b out=%h bs=%0d rs1=%h rs2=%h ir=%b",
                     out_valid, busy, state_out, dp_bs, dp_rs1, dp_rs2, in_ready);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        accept_req(rk, s, 1'b0);
        run_body(rk, s, 1'b0, ref_round(rk, s, 1'b0));
        release_out(ref_round(rk, s, 1'b0));
    endtask

`ifdef AES32_SEQ_LAST_EN
    task automatic test_last();
        accept_req(128'h0, 128'h0, 1'b1);
        run_body(128'h0, 128'h0, 1'b1, {16{8'h52}});
        release_out({16{8'h52}});
        last_in = 1'b0;
    endtask
`endif

    initial begin
        clk       = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        state_in  = '0;
        rk_in     = '0;
        tbl_ok    = 1'b0;
`ifdef AES32_SEQ_LAST_EN
        last_in   = 1'b0;
`endif
        for (int x = 0; x < 256; x++)
            inv_sb[fwd_sbox(8'(x))] = 8'(x);
        tbl_ok = 1'b1;

        test_reset();
        test_zero();
        test_ones();
        test_order();
        test_back_to_back();
        test_reset_mid();
`ifdef AES32_SEQ_LAST_EN
        test_last();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
